// File: rtl/dmux_route_ctrl.sv
// Routing controller for a 1-to-2 demux: steers accepted words into two
// registered output slots by tag, alternate or forced mode, with drain-before-mode-change.
module dmux_route_ctrl #(
  parameter int DW    = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic             in_dest,
  input  logic [1:0]       mode,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [DW-1:0]    out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [DW-1:0]    out1_data,
  output logic             sel,
  output logic             busy,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  input  logic             clr_cnt
);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t     state, state_nxt;
  logic [1:0] mode_q;
  logic       mode_ld;
  logic       rr;
  logic       target;
  logic       tgt_free;
  logic       accept;
  logic       load0, load1;
  logic       hs0, hs1;
  logic       v0_nxt, v1_nxt;
  logic       slots_empty_nxt;

  always_comb begin
    target = 1'b0;
    unique case (mode_q)
      2'b00: target = in_dest;
      2'b01: target = rr;
      2'b10: target = 1'b0;
      2'b11: target = 1'b1;
      default: target = 1'b0;
    endcase
  end

  assign tgt_free = target ? (!out1_valid || out1_ready) : (!out0_valid || out0_ready);
  // rst_n gates in_ready so nothing looks acceptable while reset is held
  assign in_ready = rst_n && (state == RUN) && (mode == mode_q) && tgt_free;
  assign accept   = in_valid && in_ready;
  assign load0    = accept && !target;
  assign load1    = accept && target;
  assign hs0      = out0_valid && out0_ready;
  assign hs1      = out1_valid && out1_ready;

  // Slot occupancy after this edge; a reload wins over a same-cycle handshake
  assign v0_nxt          = load0 || (out0_valid && !out0_ready);
  assign v1_nxt          = load1 || (out1_valid && !out1_ready);
  assign slots_empty_nxt = !v0_nxt && !v1_nxt;

  always_comb begin
    state_nxt = state;
    mode_ld   = 1'b0;
    unique case (state)
      RUN: begin
        if (mode != mode_q) begin
          if (slots_empty_nxt) mode_ld = 1'b1;
          else                 state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (slots_empty_nxt) begin
          mode_ld   = 1'b1;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      mode_q <= '0;
    end else begin
      state <= state_nxt;
      if (mode_ld) mode_q <= mode;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr         <= 1'b0;
      sel        <= 1'b0;
      out0_valid <= 1'b0;
      out1_valid <= 1'b0;
      out0_data  <= '0;
      out1_data  <= '0;
    end else begin
      out0_valid <= v0_nxt;
      out1_valid <= v1_nxt;
      if (load0) out0_data <= in_data;
      if (load1) out1_data <= in_data;
      if (accept) begin
        sel <= target;
        if (mode_q == 2'b01) rr <= ~rr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (clr_cnt) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (hs0 && (cnt0 != '1)) cnt0 <= cnt0 + CNT_W'(1);
      if (hs1 && (cnt1 != '1)) cnt1 <= cnt1 + CNT_W'(1);
    end
  end

  assign busy = (state == DRAIN) || out0_valid || out1_valid;

endmodule

// File: tb/tb_dmux_route_ctrl.sv
// Directed bench for dmux_route_ctrl: tag, alternate, forced, drain,
// counter saturation/clear and asynchronous reset scenarios.
module tb_dmux_route_ctrl;

  localparam int DW    = 8;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic             in_dest;
  logic [1:0]       mode;
  logic             out0_valid, out1_valid;
  logic             out0_ready, out1_ready;
  logic [DW-1:0]    out0_data, out1_data;
  logic             sel;
  logic             busy;
  logic [CNT_W-1:0] cnt0, cnt1;
  logic             clr_cnt;

  int checks = 0;
  int errors = 0;

  dmux_route_ctrl #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_dest    (in_dest),
    .mode       (mode),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .sel        (sel),
    .busy       (busy),
    .cnt0       (cnt0),
    .cnt1       (cnt1),
    .clr_cnt    (clr_cnt)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs then change and settle away from the edge
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'h5C; in_dest = 1'b0; mode = 2'b00;
    out0_ready = 1'b1; out1_ready = 1'b1; clr_cnt = 1'b0;
    #3;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    checks++; if ({out0_valid, out1_valid} !== 2'b00) begin errors++; $display("FAIL rst_valid got %b want 00", {out0_valid, out1_valid}); end
    checks++; if ({out0_data, out1_data} !== 16'h0000) begin errors++; $display("FAIL rst_data got %h want 0000", {out0_data, out1_data}); end
    checks++; if ({sel, busy, cnt0, cnt1} !== 6'b0) begin errors++; $display("FAIL rst_misc got %b want 000000", {sel, busy, cnt0, cnt1}); end
    step(); step();
    rst_n = 1'b1; in_valid = 1'b0;
    step();
  endtask

  task automatic test_tag();
    mode = 2'b00; out0_ready = 1'b1; out1_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'hA0; in_dest = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL tag_rdy_a got %b want 1", in_ready); end
    step();
    in_data = 8'hB1; in_dest = 1'b1; #1;
    checks++; if ({out0_valid, out0_data, sel} !== {1'b1, 8'hA0, 1'b0}) begin errors++; $display("FAIL tag_out0 got v%b d%h s%b want v1 da0 s0", out0_valid, out0_data, sel); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL tag_rdy_b got %b want 1", in_ready); end
    step();
    in_valid = 1'b0; #1;
    checks++; if ({out1_valid, out1_data, sel, out0_valid} !== {1'b1, 8'hB1, 1'b1, 1'b0}) begin errors++; $display("FAIL tag_out1 got v%b d%h s%b v0%b want v1 db1 s1 v00", out1_valid, out1_data, sel, out0_valid); end
    step();
    checks++; if ({cnt0, cnt1, busy} !== {2'd1, 2'd1, 1'b0}) begin errors++; $display("FAIL tag_cnt got c0=%0d c1=%0d busy=%b want 1 1 0", cnt0, cnt1, busy); end
  endtask

  task automatic test_alternate();
    logic [7:0] words [4];
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
    clr_cnt = 1'b1; mode = 2'b01; in_valid = 1'b0; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL alt_modechg_rdy got %b want 0", in_ready); end
    step();
    clr_cnt = 1'b0;
    // Both consumers ready: one word per cycle, destinations alternate from out0
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = words[i]; #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL alt_rdy%0d got %b want 1", i, in_ready); end
      step();
      if (i % 2 == 0) begin
        checks++; if ({out0_valid, out0_data, sel} !== {1'b1, words[i], 1'b0}) begin errors++; $display("FAIL alt_w%0d got v0%b d%h s%b want v01 d%h s0", i, out0_valid, out0_data, sel, words[i]); end
      end else begin
        checks++; if ({out1_valid, out1_data, sel} !== {1'b1, words[i], 1'b1}) begin errors++; $display("FAIL alt_w%0d got v1%b d%h s%b want v11 d%h s1", i, out1_valid, out1_data, sel, words[i]); end
      end
    end
    in_valid = 1'b0;
    step();
    // out1 stalled: 33 still reaches out0, 44 is held back
    out1_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h11; step();
    checks++; if ({out0_valid, out0_data} !== {1'b1, 8'h11}) begin errors++; $display("FAIL alt_rr_restart got v%b d%h want v1 d11", out0_valid, out0_data); end
    in_data = 8'h22; step();
    in_data = 8'h33; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL alt_stall_rdy33 got %b want 1", in_ready); end
    step();
    in_data = 8'h44; #1;
    checks++; if ({in_ready, out0_data, out1_data} !== {1'b0, 8'h33, 8'h22}) begin errors++; $display("FAIL alt_stall44 got rdy%b d0=%h d1=%h want rdy0 d0=33 d1=22", in_ready, out0_data, out1_data); end
    step();
    checks++; if ({in_ready, out0_valid} !== 2'b00) begin errors++; $display("FAIL alt_stall44b got rdy%b v0%b want 00", in_ready, out0_valid); end
    out1_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL alt_unstall got %b want 1", in_ready); end
    step();
    in_valid = 1'b0; #1;
    checks++; if ({out1_valid, out1_data} !== {1'b1, 8'h44}) begin errors++; $display("FAIL alt_w44 got v%b d%h want v1 d44", out1_valid, out1_data); end
    step();
    checks++; if ({busy, cnt0, cnt1} !== {1'b0, 2'd3, 2'd3}) begin errors++; $display("FAIL alt_end got busy%b c0=%0d c1=%0d want 0 3 3", busy, cnt0, cnt1); end
  endtask

  task automatic test_force();
    clr_cnt = 1'b1; mode = 2'b11; in_valid = 1'b0; step();
    clr_cnt = 1'b0; out1_ready = 1'b0; out0_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'hA1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL frc_rdy1 got %b want 1", in_ready); end
    step();
    in_data = 8'hA2; #1;
    checks++; if ({in_ready, out1_valid, out1_data} !== {1'b0, 1'b1, 8'hA1}) begin errors++; $display("FAIL frc_hold got rdy%b v%b d%h want rdy0 v1 da1", in_ready, out1_valid, out1_data); end
    step();
    out1_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL frc_rdy2 got %b want 1", in_ready); end
    step();
    in_valid = 1'b0; #1;
    checks++; if ({out1_valid, out1_data, cnt1} !== {1'b1, 8'hA2, 2'd1}) begin errors++; $display("FAIL frc_w2 got v%b d%h c1=%0d want v1 da2 1", out1_valid, out1_data, cnt1); end
    step();
    checks++; if ({out1_valid, cnt1, cnt0} !== {1'b0, 2'd2, 2'd0}) begin errors++; $display("FAIL frc_cnt got v%b c1=%0d c0=%0d want v0 2 0", out1_valid, cnt1, cnt0); end
  endtask

  task automatic test_drain();
    mode = 2'b10; in_valid = 1'b0; step();
    out0_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h5A; step();
    mode = 2'b11; in_data = 8'h6B; #1;
    checks++; if ({in_ready, busy} !== 2'b01) begin errors++; $display("FAIL drn_enter got rdy%b busy%b want 0 1", in_ready, busy); end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if ({in_ready, busy, out0_valid} !== 3'b011) begin errors++; $display("FAIL drn_hold%0d got rdy%b busy%b v0%b want 0 1 1", i, in_ready, busy, out0_valid); end
    end
    step();
    out0_ready = 1'b1; #1;
    checks++; if ({in_ready, busy} !== 2'b01) begin errors++; $display("FAIL drn_last got rdy%b busy%b want 0 1", in_ready, busy); end
    step();
    checks++; if ({in_ready, busy, out0_valid} !== 3'b100) begin errors++; $display("FAIL drn_exit got rdy%b busy%b v0%b want 1 0 0", in_ready, busy, out0_valid); end
    step();
    in_valid = 1'b0; #1;
    checks++; if ({out1_valid, out1_data, sel, out0_valid} !== {1'b1, 8'h6B, 1'b1, 1'b0}) begin errors++; $display("FAIL drn_newmode got v1%b d%h s%b v0%b want 1 6b 1 0", out1_valid, out1_data, sel, out0_valid); end
    step();
  endtask

  task automatic test_saturate();
    mode = 2'b10; clr_cnt = 1'b1; in_valid = 1'b0; out0_ready = 1'b1; step();
    clr_cnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'(i + 1); step();
    end
    in_valid = 1'b0; step();
    checks++; if (cnt0 !== 2'd3) begin errors++; $display("FAIL sat_cnt0 got %0d want 3", cnt0); end
    in_valid = 1'b1; in_data = 8'h77; step();
    in_valid = 1'b0; clr_cnt = 1'b1; #1;
    checks++; if (out0_valid !== 1'b1) begin errors++; $display("FAIL sat_clr_setup got v%b want 1", out0_valid); end
    step();
    clr_cnt = 1'b0;
    checks++; if (cnt0 !== 2'd0) begin errors++; $display("FAIL sat_clr_prio got %0d want 0", cnt0); end
    in_valid = 1'b1; in_data = 8'h78; step();
    in_valid = 1'b0; step();
    checks++; if (cnt0 !== 2'd1) begin errors++; $display("FAIL sat_after_clr got %0d want 1", cnt0); end
  endtask

  task automatic test_reset_mid();
    mode = 2'b01; in_valid = 1'b0; step();
    out0_ready = 1'b0; out1_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h31; step();
    in_data = 8'h42; step();
    checks++; if ({out0_valid, out1_valid, out0_data, out1_data} !== {2'b11, 8'h31, 8'h42}) begin errors++; $display("FAIL rstm_setup got v%b%b d0=%h d1=%h want 11 31 42", out0_valid, out1_valid, out0_data, out1_data); end
    mode = 2'b00; in_dest = 1'b1; in_data = 8'h99;
    rst_n = 1'b0; #1;
    checks++; if ({out0_valid, out1_valid, out0_data, out1_data, sel, busy, in_ready} !== 21'b0) begin errors++; $display("FAIL rstm_async got v%b%b d0=%h d1=%h s%b b%b r%b want all 0", out0_valid, out1_valid, out0_data, out1_data, sel, busy, in_ready); end
    step();
    rst_n = 1'b1; out0_ready = 1'b1; out1_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstm_rdy got %b want 1", in_ready); end
    step();
    in_valid = 1'b0; #1;
    checks++; if ({out1_valid, out1_data, out0_valid, sel} !== {1'b1, 8'h99, 1'b0, 1'b1}) begin errors++; $display("FAIL rstm_tag got v1%b d%h v0%b s%b want 1 99 0 1", out1_valid, out1_data, out0_valid, sel); end
    step();
  endtask

  initial begin
    test_reset();
    test_tag();
    test_alternate();
    test_force();
    test_drain();
    test_saturate();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
